// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: NREQ valid/ready lanes with packed addr/data.
// master = execution units, slave = regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the regfile write port plus a RAW scoreboard.
// Ports: clk, rst (sync, active-low), wb (request lanes), rf_we/waddr/wdata
// (registered write port), iss_valid/iss_addr (mark pending),
// chk_addr1/2 -> chk_busy1/2 (pending lookup).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   wb,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic [AW-1:0]         chk_addr1,
  input  logic [AW-1:0]         chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 2 ** AW;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            found;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && wb.req_valid[j]) begin
        found  = 1'b1;
        gidx   = PW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

  // Nothing is accepted while in reset.
  assign wb.req_ready = rst ? gnt : '0;
  assign xfer         = rst && found;
  assign sel_addr     = wb.req_addr[gidx*AW +: AW];
  assign sel_data     = wb.req_data[gidx*DW +: DW];

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    if (xfer) begin
      ptr_d   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      we_d    = (sel_addr != '0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
      busy_d[sel_addr] = 1'b0;
    end
    // Set after clear: a fresh issue to the same register is the newer writer.
    if (iss_valid && iss_addr != '0) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
// Each task drives one scenario and checks against hand-computed values.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk;
  logic          rst;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          chk_busy1;
  logic          chk_busy2;

  int checks;
  int failures;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    wb.req_addr[i*AW +: AW] = a;
    wb.req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wb.req_valid = '0;
    iss_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    wb.req_valid = 3'b111;
    set_req(0, 5'd5, 32'h11);
    set_req(1, 5'd6, 32'h22);
    set_req(2, 5'd7, 32'h33);
    chk_addr1 = 5'd5;
    chk_addr2 = 5'd7;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (wb.req_ready !== 3'b000) begin
        failures++;
        $display("FAIL reset_ready got=%b exp=000", wb.req_ready);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
        failures++;
        $display("FAIL reset_rf got=%b/%0d/%h exp=0/0/0",
                 rf_we, rf_waddr, rf_wdata);
      end
      checks++;
      if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy got=%b%b exp=00", chk_busy1, chk_busy2);
      end
    end
    wb.req_valid = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'hDEADBEEF);
    wb.req_valid = 3'b001;
    #1;
    checks++;
    if (wb.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL single_ready got=%b exp=001", wb.req_ready);
    end
    tick();
    wb.req_valid = '0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_rf got=%b/%0d/%h exp=1/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    do_reset();
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    wb.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_g = 3'b001 << (c % 3);
      #1;
      checks++;
      if (wb.req_ready !== exp_g) begin
        failures++;
        $display("FAIL rr_grant%0d got=%b exp=%b", c, wb.req_ready, exp_g);
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'((c % 3) + 1) ||
          rf_wdata !== 32'(32'hA0 + (c % 3))) begin
        failures++;
        $display("FAIL rr_write%0d got=%b/%0d/%h exp=1/%0d/%h", c, rf_we,
                 rf_waddr, rf_wdata, (c % 3) + 1, 32'hA0 + (c % 3));
      end
    end
    wb.req_valid = 3'b100;
    #1;
    checks++;
    if (wb.req_ready !== 3'b100) begin
      failures++;
      $display("FAIL rr_only2 got=%b exp=100", wb.req_ready);
    end
    tick();
    wb.req_valid = 3'b111;
    #1;
    checks++;
    if (wb.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL rr_wrap got=%b exp=001", wb.req_ready);
    end
    tick();
    wb.req_valid = '0;
  endtask

  task automatic test_zero_reg();
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    tick();
    iss_valid = 1'b0;
    chk_addr1 = 5'd9;
    chk_addr2 = 5'd0;
    set_req(1, 5'd0, 32'hCAFE);
    wb.req_valid = 3'b010;
    #1;
    checks++;
    if (wb.req_ready !== 3'b010) begin
      failures++;
      $display("FAIL zero_ready got=%b exp=010", wb.req_ready);
    end
    tick();
    wb.req_valid = '0;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_we got=%b exp=0", rf_we);
    end
    checks++;
    if (chk_busy1 !== 1'b1 || chk_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy got=%b%b exp=10", chk_busy1, chk_busy2);
    end
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (chk_busy2 !== 1'b0) begin
      failures++;
      $display("FAIL zero_issue got=%b exp=0", chk_busy2);
    end
  endtask

  task automatic test_scoreboard();
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd8;
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (chk_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_set got=%b exp=1", chk_busy1);
    end
    set_req(0, 5'd7, 32'h77);
    wb.req_valid = 3'b001;
    #1;
    checks++;
    if (chk_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_pre_clear got=%b exp=1", chk_busy1);
    end
    tick();
    wb.req_valid = '0;
    checks++;
    if (chk_busy1 !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      failures++;
      $display("FAIL sb_clear got=%b/%b/%0d exp=0/1/7",
               chk_busy1, rf_we, rf_waddr);
    end
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    tick();
    set_req(1, 5'd7, 32'h78);
    wb.req_valid = 3'b010;
    tick();
    wb.req_valid = '0;
    iss_valid = 1'b0;
    checks++;
    if (chk_busy1 !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h78) begin
      failures++;
      $display("FAIL sb_set_wins got=%b/%b/%h exp=1/1/78",
               chk_busy1, rf_we, rf_wdata);
    end
    iss_valid = 1'b1;
    iss_addr  = 5'd8;
    set_req(2, 5'd7, 32'h79);
    wb.req_valid = 3'b100;
    tick();
    wb.req_valid = '0;
    iss_valid = 1'b0;
    checks++;
    if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sb_diff got=%b%b exp=01", chk_busy1, chk_busy2);
    end
  endtask

  task automatic test_reset_mid();
    chk_addr1 = 5'd3;
    iss_valid = 1'b1;
    iss_addr  = 5'd3;
    set_req(0, 5'd10, 32'hAA);
    wb.req_valid = 3'b001;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (chk_busy1 !== 1'b1 || rf_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup got=%b/%b exp=1/1", chk_busy1, rf_we);
    end
    set_req(0, 5'd11, 32'hBB);
    rst = 1'b0;
    #1;
    checks++;
    if (wb.req_ready !== 3'b000) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=000", wb.req_ready);
    end
    tick();
    rst = 1'b1;
    checks++;
    if (rf_we !== 1'b0 || chk_busy1 !== 1'b0 || rf_waddr !== 5'd0) begin
      failures++;
      $display("FAIL mid_state got=%b/%b/%0d exp=0/0/0",
               rf_we, chk_busy1, rf_waddr);
    end
    wb.req_valid = 3'b111;
    #1;
    checks++;
    if (wb.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL mid_ptr got=%b exp=001", wb.req_ready);
    end
    tick();
    wb.req_valid = '0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;
    iss_valid    = 1'b0;
    iss_addr     = '0;
    chk_addr1    = '0;
    chk_addr2    = '0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
